// File: rtl/morse_symbol_decoder.sv
// Morse key timer: classifies presses as dot/dash, groups them into letters
// and emits one registered letter per inter-letter gap.
module morse_symbol_decoder #(
  parameter int DOT_MAX    = 25_000_000,
  parameter int LETTER_GAP = 50_000_000,
  parameter int CNT_W      = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic       letter_valid,
  output logic [4:0] letter_code,
  output logic [2:0] letter_len,
  output logic       letter_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ARM, IDLE, PRESS, GAP
  } state_t;

  localparam logic [CNT_W-1:0] DOT_C = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_C = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [4:0]       r_buf;
  logic [2:0]       r_cnt;
  logic             r_err;
  logic             r_valid;
  logic [4:0]       r_code;
  logic [2:0]       r_len;
  logic             r_lerr;

  state_t           w_state_n;
  logic [CNT_W-1:0] w_timer_n;
  logic [CNT_W-1:0] w_timer_inc;
  logic [4:0]       w_buf_n;
  logic [2:0]       w_cnt_n;
  logic             w_err_n;
  logic             w_emit;
  logic             w_dash;

  assign w_timer_inc = r_timer + ONE_C;
  assign w_dash      = (r_timer > DOT_C);

  always_comb begin
    w_state_n = r_state;
    w_timer_n = r_timer;
    w_buf_n   = r_buf;
    w_cnt_n   = r_cnt;
    w_err_n   = r_err;
    w_emit    = 1'b0;
    unique case (r_state)
      ARM: begin
        if (!key) w_state_n = IDLE;
      end
      IDLE: begin
        if (key) begin
          w_state_n = PRESS;
          w_timer_n = ONE_C;
          w_buf_n   = '0;
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
        end
      end
      PRESS: begin
        if (key) begin
          if (r_timer != '1) w_timer_n = w_timer_inc;
        end else begin
          // sixth and later symbols only mark the letter as bad
          if (r_cnt < 3'd5) begin
            w_buf_n = {r_buf[3:0], w_dash};
            w_cnt_n = r_cnt + 3'd1;
          end else begin
            w_err_n = 1'b1;
          end
          w_state_n = GAP;
          w_timer_n = ONE_C;
        end
      end
      GAP: begin
        if (key) begin
          w_state_n = PRESS;
          w_timer_n = ONE_C;
        end else if (w_timer_inc == GAP_C) begin
          w_emit    = 1'b1;
          w_state_n = IDLE;
          w_timer_n = '0;
          w_buf_n   = '0;
          w_cnt_n   = '0;
          w_err_n   = 1'b0;
        end else begin
          w_timer_n = w_timer_inc;
        end
      end
      default: w_state_n = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARM;
      r_timer <= '0;
      r_buf   <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_code  <= '0;
      r_len   <= '0;
      r_lerr  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_timer <= w_timer_n;
      r_buf   <= w_buf_n;
      r_cnt   <= w_cnt_n;
      r_err   <= w_err_n;
      r_valid <= w_emit;
      if (w_emit) begin
        r_code <= r_buf;
        r_len  <= r_cnt;
        r_lerr <= r_err;
      end
    end
  end

  assign letter_valid = r_valid;
  assign letter_code  = r_code;
  assign letter_len   = r_len;
  assign letter_err   = r_lerr;
  assign busy         = (r_state == PRESS) || (r_state == GAP);

endmodule

// File: tb/tb_morse_symbol_decoder.sv
// Scoreboard bench for morse_symbol_decoder with short timing
// parameters (DOT_MAX=4, LETTER_GAP=8).
module tb_morse_symbol_decoder;

  typedef struct {
    logic [4:0] code;
    logic [2:0] len;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic       letter_valid;
  logic [4:0] letter_code;
  logic [2:0] letter_len;
  logic       letter_err;
  logic       busy;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_strobe = 0;
  logic r_prev_valid = 1'b0;
  exp_t q[$];

  morse_symbol_decoder #(
    .DOT_MAX(4),
    .LETTER_GAP(8),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key(key),
    .letter_valid(letter_valid),
    .letter_code(letter_code),
    .letter_len(letter_len),
    .letter_err(letter_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [4:0] c,
                      input logic [2:0] l,
                      input logic e);
    exp_t x;
    x.code = c;
    x.len  = l;
    x.err  = e;
    q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!rst && letter_valid) begin
      exp_t x;
      n_strobe++;
      chk("pulse", 32'(r_prev_valid), 32'd0);
      if (q.size() == 0) begin
        chk("unexp_strobe", 32'd1, 32'd0);
      end else begin
        x = q.pop_front();
        chk("code", 32'(letter_code), 32'(x.code));
        chk("len", 32'(letter_len), 32'(x.len));
        chk("err", 32'(letter_err), 32'(x.err));
      end
    end
    r_prev_valid = rst ? 1'b0 : letter_valid;
  end

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      key = lvl;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input int n);
    for (int i = 0; i < n; i++) begin
      key = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_press", 32'(busy), 32'd1);
    end
  endtask

  task automatic gap_mid(input int n);
    for (int i = 0; i < n; i++) begin
      key = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_gap", 32'(busy), 32'd1);
    end
  endtask

  task automatic gap_end();
    gap_mid(7);
    key = 1'b0;
    @(posedge clk);
    #1;
    chk("valid_at_8", 32'(letter_valid), 32'd1);
    chk("busy_fall", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int s0;
    key = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(letter_valid), 32'd0);
    chk("rst_code", 32'(letter_code), 32'd0);
    chk("rst_len", 32'(letter_len), 32'd0);
    chk("rst_err", 32'(letter_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    drive(1'b0, 2);

    push(5'b00000, 3'd1, 1'b0);
    press(4);
    gap_end();
    drive(1'b0, 2);

    push(5'b00001, 3'd1, 1'b0);
    press(5);
    gap_end();
    drive(1'b0, 2);

    push(5'b00001, 3'd2, 1'b0);
    press(2);
    gap_mid(3);
    press(6);
    gap_end();
    drive(1'b0, 3);

    #4;
    rst = 1'b1;
    #1;
    chk("arst_code", 32'(letter_code), 32'd0);
    chk("arst_len", 32'(letter_len), 32'd0);
    chk("arst_err", 32'(letter_err), 32'd0);
    chk("arst_valid", 32'(letter_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    s0 = n_strobe;
    drive(1'b0, 20);
    chk("quiet_strobes", 32'(n_strobe - s0), 32'd0);
    chk("quiet_busy", 32'(busy), 32'd0);

    push(5'b00000, 3'd2, 1'b0);
    press(2);
    gap_mid(7);
    press(2);
    gap_end();
    drive(1'b0, 2);

    push(5'b00000, 3'd5, 1'b1);
    for (int i = 0; i < 6; i++) begin
      press(2);
      if (i < 5) gap_mid(3);
    end
    gap_end();
    drive(1'b0, 2);

    push(5'b00000, 3'd1, 1'b0);
    press(3);
    gap_end();
    drive(1'b0, 2);

    s0 = n_strobe;
    press(3);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 10);
    chk("arm_busy", 32'(busy), 32'd0);
    drive(1'b0, 8);
    chk("rst_press_strobes", 32'(n_strobe - s0), 32'd0);
    chk("rst_press_busy", 32'(busy), 32'd0);

    push(5'b00001, 3'd1, 1'b0);
    press(6);
    gap_end();
    drive(1'b0, 3);

    chk("pending", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
